// File: rtl/cc3000_spi_apb_if.sv
// APB3 completer bus bundle for the CC3000 SPI bridge.
interface cc3000_spi_apb_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE,
    output PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE,
    input  PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/cc3000_spi_apb.sv
// APB3 to SPI (mode 1) bridge for the CC3000 with TX FIFO.
// Optional IRQ path enabled by defining CC3000_SPI_IRQ_EN.
module cc3000_spi_apb #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic SYSCLK,
  input  logic SYSRESET,
  cc3000_spi_apb_if.slave apb,
  output logic SPI_SCLK,
  output logic SPI_MOSI,
  output logic SPI_CS_N,
  input  logic SPI_MISO,
  input  logic SPI_IRQ_N,
  output logic INT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_LEAD, S_SHIFT, S_TAIL
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  hcnt_q, hcnt_d;
  logic [2:0]  bit_q, bit_d;
  logic        sclk_q, sclk_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rsh_q, rsh_d;

  logic        wait_q;
  logic        en_q, cs_q, irqen_q;
  logic [3:0]  div_q;
  logic [7:0]  rxdata_q;
  logic        rxvalid_q, ovr_q;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q;

  logic        access, done, bad_addr;
  logic [1:0]  sel;
  logic        wr, rd, wr_ctrl, wr_stat, wr_tx, rd_rx;
  logic        full, empty, push, pop;
  logic        start, half_end, launch, load_rx;
  logic        busy, irq;
  logic [31:0] rdata;

  // One wait state: PREADY rises in the second ACCESS cycle.
  assign access   = apb.PSEL & apb.PENABLE;
  assign done     = access & wait_q;
  assign sel      = apb.PADDR[3:2];
  assign bad_addr = |apb.PADDR[7:4];
  assign wr       = done & apb.PWRITE & ~bad_addr;
  assign rd       = done & ~apb.PWRITE & ~bad_addr;
  assign wr_ctrl  = wr & (sel == 2'd0);
  assign wr_stat  = wr & (sel == 2'd1);
  assign wr_tx    = wr & (sel == 2'd2);
  assign rd_rx    = rd & (sel == 2'd3);

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign push  = wr_tx & ~full;
  assign busy  = (state_q != S_IDLE);

  assign apb.PREADY  = done;
  assign apb.PSLVERR = done & (bad_addr
                     | ((sel == 2'd3) & apb.PWRITE)
                     | ((sel == 2'd2) & (~apb.PWRITE | full)));

  always_comb begin
    rdata = '0;
    unique case (sel)
      2'd0: rdata = {24'd0, div_q, 1'b0, irqen_q, cs_q, en_q};
      2'd1: rdata = {26'd0, irq, ovr_q, rxvalid_q, empty, full, busy};
      2'd2: rdata = '0;
      2'd3: rdata = {24'd0, rxdata_q};
    endcase
  end

  assign apb.PRDATA = rd ? rdata : '0;

  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      wait_q    <= 1'b0;
      en_q      <= 1'b0;
      cs_q      <= 1'b0;
      irqen_q   <= 1'b0;
      div_q     <= '0;
      rxdata_q  <= '0;
      rxvalid_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      wait_q <= access & ~wait_q;
      if (wr_ctrl) begin
        en_q    <= apb.PWDATA[0];
        cs_q    <= apb.PWDATA[1];
        irqen_q <= apb.PWDATA[2];
        div_q   <= apb.PWDATA[7:4];
      end
      // A completing byte wins over a same-cycle clear.
      if (load_rx) begin
        rxdata_q  <= rsh_q;
        rxvalid_q <= 1'b1;
      end else if (rd_rx) begin
        rxvalid_q <= 1'b0;
      end
      if (load_rx && rxvalid_q) begin
        ovr_q <= 1'b1;
      end else if (wr_stat && apb.PWDATA[4]) begin
        ovr_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= apb.PWDATA[7:0];
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + (AW+1)'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - (AW+1)'(1);
      end
    end
  end

  assign start    = en_q & cs_q & ~empty;
  assign half_end = (hcnt_q >= div_q);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    tx_d    = tx_q;
    rsh_d   = rsh_q;
    pop     = 1'b0;
    load_rx = 1'b0;
    launch  = 1'b0;
    unique case (state_q)
      S_IDLE: launch = start;
      S_LEAD: begin
        if (half_end) begin
          hcnt_d  = '0;
          sclk_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          hcnt_d = hcnt_q + 4'd1;
        end
      end
      S_SHIFT: begin
        if (!half_end) begin
          hcnt_d = hcnt_q + 4'd1;
        end else if (sclk_q) begin
          hcnt_d = '0;
          sclk_d = 1'b0;
          rsh_d  = {rsh_q[6:0], SPI_MISO};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_TAIL;
        end else begin
          // Bit 7 was already presented in LEAD.
          hcnt_d = '0;
          sclk_d = 1'b1;
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      S_TAIL: begin
        if (half_end) begin
          load_rx = 1'b1;
          state_d = S_IDLE;
          launch  = start;
        end else begin
          hcnt_d = hcnt_q + 4'd1;
        end
      end
    endcase
    if (launch) begin
      pop     = 1'b1;
      tx_d    = mem_q[rptr_q];
      hcnt_d  = '0;
      bit_d   = '0;
      state_d = S_LEAD;
    end
  end

  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      tx_q    <= '0;
      rsh_q   <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      tx_q    <= tx_d;
      rsh_q   <= rsh_d;
    end
  end

  assign SPI_SCLK = sclk_q;
  assign SPI_MOSI = tx_q[7];
  assign SPI_CS_N = ~cs_q;

`ifdef CC3000_SPI_IRQ_EN
  logic irq_s1_q, irq_s2_q, int_q;
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      irq_s1_q <= 1'b1;
      irq_s2_q <= 1'b1;
      int_q    <= 1'b0;
    end else begin
      irq_s1_q <= SPI_IRQ_N;
      irq_s2_q <= irq_s1_q;
      int_q    <= irqen_q & (~irq_s2_q | rxvalid_q);
    end
  end
  assign irq = ~irq_s2_q;
  assign INT = int_q;
  logic unused_ok;
  assign unused_ok = ^{apb.PWDATA[31:8], apb.PADDR[1:0]};
`else
  assign irq = 1'b0;
  assign INT = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{apb.PWDATA[31:8], apb.PADDR[1:0], SPI_IRQ_N};
`endif
endmodule
